// File: rtl/ddr_pkg.sv
// ddr_pkg: shared state encoding, default widths and words-per-sample helper for the RNG packer
package ddr_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_t;
  localparam int GC_W_DEF = 48;
  localparam int OUT_W_DEF = 256;
  function automatic int spw(input int out_w, input int sym_w, input int lanes);
    return out_w / (sym_w * lanes);
  endfunction
endpackage

// File: rtl/ddr_rng_fifo.sv
// ddr_rng_fifo: first-word-fall-through FIFO that accepts a push while full if a pop happens in the same cycle
module ddr_rng_fifo #(
  parameter int W = 304,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_valid,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_lvl;
  logic w_pop, w_push;
  assign o_valid = r_lvl != '0;
  assign o_full = r_lvl == (AW+1)'(DEPTH);
  assign o_level = r_lvl;
  assign o_data = o_valid ? r_mem[r_rp] : '0;
  assign w_pop = i_pop & o_valid;
  assign w_push = i_push & (~o_full | w_pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_lvl <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_lvl <= r_lvl + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_data;
endmodule

// File: rtl/ddr_rng_pack.sv
// ddr_rng_pack: captures multi-lane RNG symbols, tags them with a global counter and packs them into stream words
module ddr_rng_pack
  import ddr_pkg::*;
#(
  parameter int SYM_W = 4,
  parameter int LANES = 1,
  parameter int OUT_W = OUT_W_DEF,
  parameter int GC_W = GC_W_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int PPS_ALIGN = 1
) (
  input  logic                          clk200_i,
  input  logic                          ddr_data_rst,
  input  logic                          pps_i,
  input  logic                          start_write_ddr_i,
  input  logic                          rd_en_i,
  input  logic [LANES*SYM_W-1:0]        rng_data_i,
  input  logic [GC_W-1:0]               dq_gc_start_i,
  output logic [OUT_W-1:0]              m_axis_tdata,
  output logic [GC_W-1:0]               m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [GC_W-1:0]               current_dq_gc,
  output logic [31:0]                   drop_count,
  output logic [1:0]                    state_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int SL = SYM_W * LANES;
  localparam int SPW = spw(OUT_W, SYM_W, LANES);
  localparam int SW = SPW > 1 ? $clog2(SPW) : 1;
  state_t r_state, w_next;
  logic [SW-1:0] r_slot;
  logic [OUT_W-1:0] r_shift, w_word;
  logic [GC_W-1:0] r_gc, r_tuser, w_tuser;
  logic [31:0] r_drop;
  logic r_pps_d;
  logic w_edge, w_cap, w_last, w_flush, w_push, w_pop, w_full, w_load;
  assign w_edge = pps_i & ~r_pps_d;
  assign w_cap = r_state == RUN && rd_en_i;
  assign w_last = w_cap && r_slot == SW'(SPW - 1);
  assign w_flush = r_state == FLUSH && r_slot != '0;
  assign w_push = w_last | w_flush;
  assign w_pop = m_axis_tvalid & m_axis_tready;
  assign w_load = (r_state == IDLE && start_write_ddr_i && PPS_ALIGN == 0) ||
                  (r_state == ARMED && start_write_ddr_i && w_edge);
  assign w_tuser = (w_cap && r_slot == '0) ? r_gc : r_tuser;
  assign current_dq_gc = r_gc;
  assign drop_count = r_drop;
  assign state_o = r_state;
  always_comb begin
    w_word = r_shift;
    for (int i = 0; i < SPW; i++)
      if (w_cap && r_slot == SW'(i)) w_word[i*SL +: SL] = rng_data_i;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start_write_ddr_i ? (PPS_ALIGN != 0 ? ARMED : RUN) : IDLE;
      ARMED:   w_next = !start_write_ddr_i ? IDLE : (w_edge ? RUN : ARMED);
      RUN:     w_next = start_write_ddr_i ? RUN : FLUSH;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk200_i or posedge ddr_data_rst)
    if (ddr_data_rst) begin
      r_state <= IDLE;
      r_slot <= '0;
      r_shift <= '0;
      r_gc <= '0;
      r_tuser <= '0;
      r_drop <= '0;
      r_pps_d <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pps_d <= pps_i;
      r_tuser <= w_tuser;
      if (w_load) r_gc <= dq_gc_start_i;
      else if (w_cap) r_gc <= r_gc + GC_W'(1);
      if (w_push) begin
        r_slot <= '0;
        r_shift <= '0;
      end else if (w_cap) begin
        r_slot <= r_slot + SW'(1);
        r_shift <= w_word;
      end
      if (w_push && w_full && !w_pop && r_drop != '1) r_drop <= r_drop + 32'd1;
    end
  ddr_rng_fifo #(.W(OUT_W + GC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk200_i),
    .rst(ddr_data_rst),
    .i_push(w_push),
    .i_data({w_tuser, w_word}),
    .i_pop(m_axis_tready),
    .o_data({m_axis_tuser, m_axis_tdata}),
    .o_valid(m_axis_tvalid),
    .o_full(w_full),
    .o_level(fifo_level)
  );
endmodule

// File: tb/tb_ddr_rng_pack.sv
// tb_ddr_rng_pack: randomized directed bench with a sample-list reference model for the RNG packer
module tb_ddr_rng_pack;
  localparam int DEP = 16, SPW = 8;
  logic clk = 0, rst = 1, pps = 0, start = 0, rd_en = 0, tready = 1;
  logic [3:0] rng = 0;
  logic [7:0] rng2 = 0;
  logic [47:0] gc_start = 0;
  logic [31:0] tdata, tdata2, drop, drop2;
  logic [47:0] tuser, tuser2, gc, gc2;
  logic tvalid, tvalid2;
  logic [1:0] state, state2;
  logic [4:0] level, level2;
  int checks = 0, errors = 0;
  logic [79:0] exp_q[$];
  logic [31:0] m_word = 0;
  logic [47:0] m_gc = 0, m_tu = 0;
  int m_cnt = 0, m_drop = 0;
  bit m_run = 0;

  always #5 clk = ~clk;

  ddr_rng_pack #(.SYM_W(4), .LANES(1), .OUT_W(32), .GC_W(48), .FIFO_DEPTH(16), .PPS_ALIGN(1)) u1 (
    .clk200_i(clk), .ddr_data_rst(rst), .pps_i(pps), .start_write_ddr_i(start), .rd_en_i(rd_en),
    .rng_data_i(rng), .dq_gc_start_i(gc_start), .m_axis_tdata(tdata), .m_axis_tuser(tuser),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .current_dq_gc(gc), .drop_count(drop),
    .state_o(state), .fifo_level(level));

  ddr_rng_pack #(.SYM_W(4), .LANES(2), .OUT_W(32), .GC_W(48), .FIFO_DEPTH(16), .PPS_ALIGN(1)) u2 (
    .clk200_i(clk), .ddr_data_rst(rst), .pps_i(pps), .start_write_ddr_i(start), .rd_en_i(rd_en),
    .rng_data_i(rng2), .dq_gc_start_i(gc_start), .m_axis_tdata(tdata2), .m_axis_tuser(tuser2),
    .m_axis_tvalid(tvalid2), .m_axis_tready(tready), .current_dq_gc(gc2), .drop_count(drop2),
    .state_o(state2), .fifo_level(level2));

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && tvalid && tready) begin
      chk("word_expected", 80'(exp_q.size() != 0), 80'd1);
      if (exp_q.size() != 0) chk("word", {tuser, tdata}, exp_q.pop_front());
    end

  task automatic m_push();
    if (exp_q.size() < DEP || tready) exp_q.push_back({m_tu, m_word});
    else m_drop++;
    m_cnt = 0;
    m_word = 0;
  endtask

  task automatic m_sample(input logic [3:0] s);
    if (m_run) begin
      if (m_cnt == 0) m_tu = m_gc;
      m_word = m_word | (32'(s) << (m_cnt * 4));
      m_cnt++;
      m_gc = m_gc + 48'd1;
      if (m_cnt == SPW) m_push();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] s, input logic [7:0] s2);
    rng = s;
    rng2 = s2;
    rd_en = 1;
    m_sample(s);
    tick();
    rd_en = 0;
  endtask

  task automatic arm();
    start = 1;
    tick();
  endtask

  task automatic pps_edge(input bit with_strobe);
    pps = 1;
    rd_en = with_strobe;
    rng = 4'hF;
    tick();
    pps = 0;
    rd_en = 0;
    m_run = 1;
    m_gc = gc_start;
    m_cnt = 0;
    m_word = 0;
  endtask

  task automatic m_flush();
    if (m_cnt > 0) m_push();
    m_run = 0;
  endtask

  task automatic stop();
    start = 0;
    tick();
    m_flush();
    tick();
  endtask

  task automatic stop_with(input logic [3:0] s);
    start = 0;
    rd_en = 1;
    rng = s;
    m_sample(s);
    tick();
    rd_en = 0;
    m_flush();
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_empty", 80'(exp_q.size()), 80'd0);
  endtask

  initial begin
    logic [31:0] w2;
    logic [7:0] p;
    @(negedge clk);
    chk("rst_tdata", 80'(tdata), 80'd0);
    chk("rst_tuser", 80'(tuser), 80'd0);
    chk("rst_tvalid", 80'(tvalid), 80'd0);
    chk("rst_gc", 80'(gc), 80'd0);
    chk("rst_state", 80'(state), 80'd0);
    tick();
    rst = 0;
    // basic packing, latency and tuser tagging
    gc_start = 48'hA00000433;
    arm();
    chk("armed_state", 80'(state), 80'd1);
    repeat (5) tick();
    pps_edge(0);
    chk("run_state", 80'(state), 80'd2);
    chk("run_gc_load", 80'(gc), 80'(gc_start));
    for (int i = 0; i < 7; i++) strobe(4'(i), 8'($urandom));
    chk("tvalid_before_word", 80'(tvalid), 80'd0);
    strobe(4'd7, 8'($urandom));
    chk("tvalid_latency", 80'(tvalid), 80'd1);
    chk("basic_w0", {tuser, tdata}, {48'hA00000433, 32'h76543210});
    for (int i = 8; i < 16; i++) strobe(4'(i), 8'($urandom));
    chk("basic_w1", {tuser, tdata}, {48'hA0000043B, 32'hFEDCBA98});
    for (int i = 0; i < 3 * SPW; i++) strobe(4'($urandom), 8'($urandom));
    stop();
    chk("idle_after_stop", 80'(state), 80'd0);
    chk("gc_basic", 80'(gc), 80'(m_gc));
    drain();
    // pps gating: strobes before and on the edge are ignored
    gc_start = {16'($urandom), $urandom};
    arm();
    for (int i = 0; i < 3; i++) strobe(4'($urandom), 8'($urandom));
    chk("armed_gc_hold", 80'(gc), 80'(m_gc));
    pps_edge(1);
    chk("edge_gc_load", 80'(gc), 80'(gc_start));
    for (int i = 0; i < SPW; i++) strobe(4'($urandom), 8'($urandom));
    chk("gc_after_word", 80'(gc), 80'(gc_start + 48'd8));
    stop();
    drain();
    // backpressure, drops, and push-while-full with simultaneous pop
    tready = 0;
    arm();
    pps_edge(0);
    for (int i = 0; i < 20 * SPW; i++) strobe(4'($urandom), 8'($urandom));
    chk("bp_level", 80'(level), 80'd16);
    chk("bp_drops", 80'(drop), 80'd4);
    for (int i = 0; i < SPW - 1; i++) strobe(4'($urandom), 8'($urandom));
    tready = 1;
    strobe(4'($urandom), 8'($urandom));
    chk("full_pushpop_level", 80'(level), 80'd16);
    chk("full_pushpop_nodrop", 80'(drop), 80'd4);
    drain();
    stop();
    // flush of partial words, with and without a coincident strobe
    arm();
    pps_edge(0);
    strobe(4'd1, 8'd0);
    strobe(4'd2, 8'd0);
    strobe(4'd3, 8'd0);
    stop();
    chk("flush_word", 80'(tdata), 80'h321);
    chk("flush_idle", 80'(state), 80'd0);
    drain();
    arm();
    pps_edge(0);
    strobe(4'd1, 8'd0);
    strobe(4'd2, 8'd0);
    strobe(4'd3, 8'd0);
    stop_with(4'd4);
    chk("flush_with_strobe", 80'(tdata), 80'h4321);
    drain();
    // reset mid-word discards the partial word
    arm();
    pps_edge(0);
    for (int i = 0; i < 5; i++) strobe(4'($urandom), 8'($urandom));
    rst = 1;
    @(negedge clk);
    chk("mrst_tdata", 80'(tdata), 80'd0);
    chk("mrst_tuser", 80'(tuser), 80'd0);
    chk("mrst_tvalid", 80'(tvalid), 80'd0);
    chk("mrst_gc", 80'(gc), 80'd0);
    chk("mrst_drop", 80'(drop), 80'd0);
    chk("mrst_state", 80'(state), 80'd0);
    chk("mrst_level", 80'(level), 80'd0);
    tick();
    exp_q.delete();
    m_cnt = 0;
    m_word = 0;
    m_gc = 0;
    m_run = 0;
    m_drop = 0;
    start = 0;
    rst = 0;
    arm();
    pps_edge(0);
    repeat (10) tick();
    chk("no_partial_tvalid", 80'(tvalid), 80'd0);
    chk("no_partial_level", 80'(level), 80'd0);
    stop();
    // counter wrap and two-lane packing
    gc_start = 48'hFFFFFFFFFFFE;
    arm();
    pps_edge(0);
    w2 = 0;
    for (int i = 0; i < 4; i++) begin
      p = 8'($urandom);
      w2 = w2 | (32'(p) << (i * 8));
      strobe(4'($urandom), p);
    end
    chk("wrap_tvalid2", 80'(tvalid2), 80'd1);
    chk("wrap_tuser2", 80'(tuser2), 80'hFFFFFFFFFFFE);
    chk("wrap_tdata2", 80'(tdata2), 80'(w2));
    chk("wrap_gc2", 80'(gc2), 80'd2);
    chk("wrap_gc1", 80'(gc), 80'(m_gc));
    stop();
    drain();
    chk("final_drop", 80'(drop), 80'(m_drop));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
